sel_mux_pipe: RTL and testbench
===============================

SEL_MUX_PIPE -- requirements
Module: sel_mux_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input channel and of the output.
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Parameter SEL_W, default 2, select index width; SHALL satisfy 2**SEL_W >= N.
REQ-004 clk  input  1  single clock for all state, rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_data  input  N*WIDTH  flattened channels; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 sel  input  SEL_W  channel index, sampled with in_data on acceptance.
REQ-008 in_valid  input  1  upstream offers a transfer.
REQ-009 in_ready  output  1  block can accept; driven directly from a register.
REQ-010 out_data  output  WIDTH  selected channel, registered.
REQ-011 out_valid  output  1  out_data holds a valid item.
REQ-012 out_ready  input  1  downstream accepts out_data.

Function
REQ-013 An input transfer SHALL occur on a rising edge when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-014 On acceptance the block SHALL capture the channel selected by sel; the data path SHALL never carry unselected channels.
REQ-015 If sel >= N, the captured value SHALL be all zeros.
REQ-016 Storage is a two-entry skid buffer: main register (drives out_data) and skid register.
REQ-017 States: EMPTY (out_valid=0, in_ready=1), ONE (out_valid=1, in_ready=1), FULL (out_valid=1, in_ready=0).
REQ-018 EMPTY + input transfer -> ONE; main loaded; out_valid rises the cycle after acceptance (latency 1).
REQ-019 ONE + input transfer + output transfer -> ONE; main reloaded with new item.
REQ-020 ONE + output transfer only -> EMPTY.
REQ-021 ONE + input transfer only -> FULL; new item stored in skid register.
REQ-022 FULL + output transfer -> ONE; skid contents moved to main; no input accepted in FULL.
REQ-023 Items SHALL leave in acceptance order; no item lost or duplicated.
REQ-024 Sustained in_valid=1, out_ready=1 SHALL give one transfer per cycle.
REQ-025 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 out_data content while out_valid=0 is don't-care for the bench, but SHALL be X-free after reset.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force state EMPTY, out_valid=0, in_ready=1, out_data=0, skid register=0.
REQ-028 Reset mid-operation SHALL discard buffered items; first acceptance SHALL be possible on the first rising edge after rst falls.

Configuration
REQ-029 Macro SEL_MUX_PIPE_RANGE_ERR_EN, when defined, SHALL add output sel_err (1 bit), set on any input transfer with sel >= N, sticky until rst, reset value 0.
REQ-030 Without SEL_MUX_PIPE_RANGE_ERR_EN, port sel_err SHALL not exist; data behaviour per REQ-015 is identical in both builds.

Verification
REQ-031 WIDTH=32, N=4: channels {0x11111111,0x22222222,0x33333333,0x44444444}, sel=2, in_valid=1 one cycle, out_ready=1 -> out_valid=1 next cycle with out_data=0x33333333, then out_valid=0.
REQ-032 Stream sel=0,1,2,3 back-to-back with out_ready=1 -> outputs 0x11111111,0x22222222,0x33333333,0x44444444 on four consecutive cycles, in_ready held 1.
REQ-033 out_ready=0, offer two items (sel=1 then 3) -> in_ready=0 after second acceptance, out_data=0x22222222 stable; raise out_ready -> 0x22222222 then 0x44444444 delivered, in_ready returns 1.
REQ-034 N=3, SEL_W=2, sel=3 accepted -> out_data=0; with SEL_MUX_PIPE_RANGE_ERR_EN defined sel_err=1 and stays 1 after later valid sel values.
REQ-035 FULL state, assert rst between clock edges -> out_valid=0, in_ready=1 immediately; after release, sel=0 transfer delivers 0x11111111 only, no stale data.
REQ-036 Random in_valid/out_ready (10^4 cycles) vs. reference queue model -> order and content match, no handshake rule violation.

Source files
------------

// File: rtl/sel_mux_pipe_if.sv
// sel_mux_pipe_if: upstream/downstream handshake bundle for sel_mux_pipe.
// slave = block side (takes in_*, drives out_*), master = environment side.
interface sel_mux_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data,
    input  sel,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output sel,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: channel select mux feeding a two-entry skid buffer.
// Ports: clk, rst (async high), bus (in_data/sel/in_valid/in_ready,
// out_data/out_valid/out_ready), sel_err when SEL_MUX_PIPE_RANGE_ERR_EN.
module sel_mux_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef SEL_MUX_PIPE_RANGE_ERR_EN
  output logic sel_err,
`endif
  sel_mux_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             rdy_q;
  logic             rdy_d;
  logic             vld_q;
  logic             vld_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_ok;
  logic             in_fire;
  logic             out_fire;

  // Only the addressed channel reaches sel_data;
  // an out-of-range index yields zero.
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        sel_data = bus.in_data[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end
  end

  assign in_fire  = bus.in_valid & rdy_q;
  assign out_fire = vld_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = sel_data;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case (1'b1)
          in_fire & out_fire: begin
            main_d = sel_data;
          end
          in_fire & ~out_fire: begin
            skid_d  = sel_data;
            state_d = FULL;
          end
          ~in_fire & out_fire: begin
            state_d = EMPTY;
          end
          default: begin
            state_d = ONE;
          end
        endcase
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // Handshake flags are registered copies of the next state.
    rdy_d = (state_d != FULL);
    vld_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

`ifdef SEL_MUX_PIPE_RANGE_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (in_fire & ~sel_ok) begin
      sel_err <= 1'b1;
    end
  end
`endif

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = main_q;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// tb_sel_mux_pipe: directed checks on an N=4 and an N=3 instance,
// plus a randomized handshake run against a queue model.
module tb_sel_mux_pipe;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [31:0] ch [4];
  logic [31:0] q [$];

  sel_mux_pipe_if #(.WIDTH(32), .N(4), .SEL_W(2)) a ();
  sel_mux_pipe_if #(.WIDTH(32), .N(3), .SEL_W(2)) b ();

`ifdef SEL_MUX_PIPE_RANGE_ERR_EN
  logic err_a;
  logic err_b;
`endif

  sel_mux_pipe #(.WIDTH(32), .N(4), .SEL_W(2)) dut_a (
    .clk(clk),
    .rst(rst),
`ifdef SEL_MUX_PIPE_RANGE_ERR_EN
    .sel_err(err_a),
`endif
    .bus(a.slave)
  );

  sel_mux_pipe #(.WIDTH(32), .N(3), .SEL_W(2)) dut_b (
    .clk(clk),
    .rst(rst),
`ifdef SEL_MUX_PIPE_RANGE_ERR_EN
    .sel_err(err_b),
`endif
    .bus(b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ch();
    a.in_data = {ch[3], ch[2], ch[1], ch[0]};
    b.in_data = {ch[2], ch[1], ch[0]};
  endtask

  initial begin
    logic [31:0] exp;
    logic        fin;
    logic        fout;
    logic        stall;
    logic [31:0] hold;
    n_cmp = 0;
    n_bad = 0;
    ch[0] = 32'h11111111;
    ch[1] = 32'h22222222;
    ch[2] = 32'h33333333;
    ch[3] = 32'h44444444;
    load_ch();
    a.sel = '0; a.in_valid = 0; a.out_ready = 0;
    b.sel = '0; b.in_valid = 0; b.out_ready = 0;
    rst = 1'b1;
    #3;
    check("rst_vld", a.out_valid, 0);
    check("rst_rdy", a.in_ready, 1);
    check("rst_data", a.out_data, 0);
`ifdef SEL_MUX_PIPE_RANGE_ERR_EN
    check("rst_err", err_b, 0);
`endif
    #14 rst = 1'b0;
    step();

    // single item, latency 1
    a.sel = 2'd2; a.in_valid = 1; a.out_ready = 1;
    step();
    check("one_vld", a.out_valid, 1);
    check("one_data", a.out_data, 32'h33333333);
    a.in_valid = 0;
    step();
    check("one_drain", a.out_valid, 0);

    // back-to-back stream
    a.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      a.sel = 2'(i);
      step();
      check("strm_data", a.out_data, ch[i]);
      check("strm_vld", a.out_valid, 1);
      check("strm_rdy", a.in_ready, 1);
    end
    a.in_valid = 0;
    step();
    check("strm_end", a.out_valid, 0);

    // backpressure into FULL and drain
    a.out_ready = 0;
    a.in_valid = 1; a.sel = 2'd1;
    step();
    check("bp_rdy1", a.in_ready, 1);
    a.sel = 2'd3;
    step();
    check("bp_full", a.in_ready, 0);
    check("bp_data", a.out_data, 32'h22222222);
    a.in_valid = 0;
    step();
    check("bp_stable", a.out_data, 32'h22222222);
    check("bp_svld", a.out_valid, 1);
    a.out_ready = 1;
    step();
    check("bp_second", a.out_data, 32'h44444444);
    check("bp_rdy2", a.in_ready, 1);
    step();
    check("bp_empty", a.out_valid, 0);

    // out-of-range select on the N=3 block
    b.out_ready = 1; b.in_valid = 1; b.sel = 2'd3;
    step();
    check("oor_vld", b.out_valid, 1);
    check("oor_data", b.out_data, 0);
    b.sel = 2'd1;
    step();
    check("oor_next", b.out_data, 32'h22222222);
`ifdef SEL_MUX_PIPE_RANGE_ERR_EN
    check("oor_err", err_b, 1);
`endif
    b.in_valid = 0;
    step();
`ifdef SEL_MUX_PIPE_RANGE_ERR_EN
    check("oor_sticky", err_b, 1);
    check("err_a", err_a, 0);
`endif

    // asynchronous reset out of FULL
    a.out_ready = 0; a.in_valid = 1; a.sel = 2'd1;
    step();
    a.sel = 2'd2;
    step();
    check("pre_rst_full", a.in_ready, 0);
    a.in_valid = 0;
    #2 rst = 1'b1;
    #1;
    check("arst_vld", a.out_valid, 0);
    check("arst_rdy", a.in_ready, 1);
    check("arst_data", a.out_data, 0);
    #1 rst = 1'b0;
    a.sel = 2'd0; a.in_valid = 1; a.out_ready = 1;
    step();
    check("post_data", a.out_data, 32'h11111111);
    check("post_vld", a.out_valid, 1);
    a.in_valid = 0;
    step();
    check("post_empty", a.out_valid, 0);

    // random traffic vs queue model
    stall = 0;
    hold = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 4; k++) ch[k] = $urandom;
      load_ch();
      a.sel = 2'($urandom_range(0, 3));
      a.in_valid = 1'($urandom_range(0, 1));
      a.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (stall) begin
        check("rnd_hold_v", a.out_valid, 1);
        check("rnd_hold_d", a.out_data, hold);
      end
      fin = a.in_valid & a.in_ready;
      fout = a.out_valid & a.out_ready;
      if (fout) begin
        if (q.size() == 0) begin
          check("rnd_underflow", 1, 0);
        end else begin
          exp = q.pop_front();
          check("rnd_data", a.out_data, exp);
        end
      end
      if (fin) q.push_back(ch[a.sel]);
      stall = a.out_valid & ~a.out_ready;
      hold = a.out_data;
      step();
    end
    a.in_valid = 0; a.out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (a.out_valid) begin
        if (q.size() == 0) begin
          check("drain_extra", 1, 0);
        end else begin
          exp = q.pop_front();
          check("drain_data", a.out_data, exp);
        end
      end
      step();
    end
    check("drain_left", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
